gshare_predictor_param: RTL and testbench
=========================================

Name: gshare_predictor_param

Overview:
- Parametrised successor of the fixed 32-entry gshare predictor, sitting in the IF stage of the 5-stage pipeline.
- Provides a tagged BTB of configurable depth and a PHT of configurable size.
- Selectable prediction mode: static not-taken, bimodal, or gshare.
- The global history register (GHR) is updated speculatively at fetch and checkpoint-repaired on mispredict. The block also carries a conditional/unconditional entry type and saturating statistics counters.

Parameters:
BTB_IDX_BITS, 5, log2 of BTB entries; tag = pc[31:BTB_IDX_BITS+2]
PHT_BITS, 6, log2 of PHT entries (2-bit counters)
GHR_BITS, 6, history length; must be <= PHT_BITS
MODE, 2, 0 = static not-taken, 1 = bimodal (pc index), 2 = gshare (pc xor GHR)
PHT_INIT, 2'b01, counter reset value

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
stall  in  1  IF stalled; no speculative GHR shift, no lookup count
if_pc  in  32  fetch PC
pred_pc  out  32  predicted next PC
pred_taken  out  1  prediction taken
pred_pht_idx  out  PHT_BITS  PHT index used; carried down pipe
pred_ghr  out  GHR_BITS  GHR snapshot before this fetch; carried down pipe
upd_valid  in  1  branch/jump resolved in ID; one cycle per instruction
upd_pc  in  32  PC of resolved instruction
upd_is_cond  in  1  1 = conditional branch, 0 = jal/jalr
upd_taken  in  1  actual direction (1 for jumps)
upd_target  in  32  actual taken target
upd_pht_idx  in  PHT_BITS  pred_pht_idx that travelled with instruction
upd_ghr  in  GHR_BITS  pred_ghr that travelled with instruction
upd_mispredict  in  1  predicted next PC != actual next PC
stat_lookups  out  32  fetch count
stat_mispredicts  out  32  mispredict count

Behaviour:
Interface:
- reset reset, synchronous, active-high; clock clk.

Lookup (combinational from if_pc and current state):
- bidx = if_pc[BTB_IDX_BITS+1:2]. hit = valid[bidx] && tag[bidx] == if_pc[31:BTB_IDX_BITS+2].
- pidx depends on MODE:
  - MODE 2: if_pc[PHT_BITS+1:2] xor zero-extended GHR.
  - MODE 1: if_pc[PHT_BITS+1:2].
  - MODE 0: 0.
- pred_taken depends on MODE:
  - MODE 1/2: hit && (!cond[bidx] || PHT[pidx] >= 2).
  - MODE 0: hit && !cond[bidx] (jumps only).
- pred_pc = pred_taken ? target[bidx] : if_pc + 4, 32-bit wrap.
- pred_pht_idx = pidx. pred_ghr = GHR.

GHR (newest outcome in bit 0, shifts left):
- Priority 1, recovery: if upd_valid && upd_mispredict:
  - conditional: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - unconditional: GHR <= upd_ghr.
  - Overrides any speculative shift that cycle, regardless of stall.
- Priority 2, speculative shift: if !stall && hit && cond[bidx]: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- Otherwise GHR holds.
- In MODE 0/1 the GHR is maintained but unused for indexing.

Training (on upd_valid; does not look at stall):
- BTB write when upd_taken: at index upd_pc[BTB_IDX_BITS+1:2], write valid=1, tag, target=upd_target, cond=upd_is_cond. Replaces any aliasing entry.
- Not-taken conditional: BTB unchanged.
- PHT update when upd_is_cond: PHT[upd_pht_idx] saturating increment if taken, decrement if not (0..3).
- Jumps never touch the PHT.

Timing and boundary conditions:
- All state writes occur at posedge. A same-cycle lookup of an entry being written sees old contents.
- Tables are not cleared on mispredict; only the GHR is repaired.
- Statistics counters:
  - stat_lookups +1 per cycle with !stall.
  - stat_mispredicts +1 per upd_valid && upd_mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Reset, including mid-operation, has priority over everything:
  - all valid = 0, PHT = PHT_INIT, GHR = 0, stats = 0.
  - Hence pred_taken = 0, pred_pc = if_pc + 4, pred_ghr = 0 in the cycle after reset.
- Elaboration error if GHR_BITS > PHT_BITS or GHR_BITS < 1.

Test Plan:
1. Reset, if_pc = 0x100 -> pred_taken = 0, pred_pc = 0x104, pred_ghr = 0, stats = 0.
2. Jump train: upd_valid, upd_pc = 0x100, upd_is_cond = 0, upd_taken = 1, upd_target = 0x200 -> next cycle if_pc = 0x100 gives pred_pc = 0x200 in all MODEs; if_pc = 0x1100 (same index, different tag) gives 0x1104.
3. Gshare MODE 2, PHT_INIT = 1: two taken trainings of conditional 0x40 -> target 0x80, each with upd_ghr = 0 and upd_pht_idx = 16, then force GHR = 0 via reset-free recovery (upd_mispredict, upd_is_cond = 0, upd_ghr = 0) -> if_pc = 0x40 predicts 0x80 with pred_pht_idx = 16; three not-taken updates -> counter 0, predicts 0x44.
4. Speculative GHR: hit on conditional, pred_taken = 1, three fetches with !stall -> GHR = 3'b111 in low bits; same with stall = 1 -> GHR unchanged.
5. Recovery: same cycle as a speculative shift, upd_mispredict with upd_is_cond = 1, upd_ghr = 6'b000101, upd_taken = 0 -> GHR = 6'b001010; stat_mispredicts +1.
6. Saturation: PHT at 3 plus taken update -> stays 3; PHT at 0 plus not-taken update -> stays 0; reset asserted during an upd_valid cycle -> entry not written.

Source files
------------

// File: rtl/gshare_predictor_param.sv
// Parametrised gshare/bimodal/static branch predictor for the IF stage.
// Tagged BTB, 2-bit PHT, speculative GHR with mispredict repair, stats.
module gshare_predictor_param #(
  parameter int          BTB_IDX_BITS = 5,
  parameter int          PHT_BITS     = 6,
  parameter int          GHR_BITS     = 6,
  parameter int          MODE         = 2,
  parameter logic [1:0]  PHT_INIT     = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [31:0]         if_pc,
  output logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [PHT_BITS-1:0] pred_pht_idx,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [PHT_BITS-1:0] upd_pht_idx,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
);

  localparam int BTB_N   = 1 << BTB_IDX_BITS;
  localparam int PHT_N   = 1 << PHT_BITS;
  localparam int TAG_W   = 32 - BTB_IDX_BITS - 2;
  localparam bit USE_PHT = (MODE != 0);

  if (GHR_BITS < 1 || GHR_BITS > PHT_BITS) begin : g_ghr_err
    $error("GHR_BITS must lie in 1..PHT_BITS");
  end
  if (MODE < 0 || MODE > 2) begin : g_mode_err
    $error("MODE must be 0, 1 or 2");
  end

  // Shift one outcome into a history value, newest in bit 0.
  function automatic logic [GHR_BITS-1:0] shl(
    input logic [GHR_BITS-1:0] g,
    input logic                b
  );
    return GHR_BITS'({g, b});
  endfunction

  logic [BTB_N-1:0] valid_q;
  logic [BTB_N-1:0] cond_q;
  logic [TAG_W-1:0] tag_q [BTB_N];
  logic [31:0]      tgt_q [BTB_N];
  logic [1:0]       pht_q [PHT_N];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         lk_q, lk_d;
  logic [31:0]         mp_q, mp_d;

  logic [BTB_IDX_BITS-1:0] bidx;
  logic [TAG_W-1:0]        ftag;
  logic                    hit;
  logic                    hit_cond;
  logic [PHT_BITS-1:0]     pidx;
  logic                    ctr_taken;

  assign bidx     = if_pc[BTB_IDX_BITS+1:2];
  assign ftag     = if_pc[31:BTB_IDX_BITS+2];
  assign hit      = valid_q[bidx] && (tag_q[bidx] == ftag);
  assign hit_cond = hit && cond_q[bidx];

  if (MODE == 2) begin : g_gshare
    logic [PHT_BITS-1:0] ghr_ext;
    assign ghr_ext = PHT_BITS'(ghr_q);
    assign pidx    = if_pc[PHT_BITS+1:2] ^ ghr_ext;
  end else if (MODE == 1) begin : g_bimodal
    assign pidx = if_pc[PHT_BITS+1:2];
  end else begin : g_static
    assign pidx = '0;
  end

  assign ctr_taken    = USE_PHT && pht_q[pidx][1];
  assign pred_taken   = hit && (!cond_q[bidx] || ctr_taken);
  assign pred_pc      = pred_taken ? tgt_q[bidx] : if_pc + 32'd4;
  assign pred_pht_idx = pidx;
  assign pred_ghr     = ghr_q;

  assign stat_lookups     = lk_q;
  assign stat_mispredicts = mp_q;

  logic                    btb_we;
  logic [BTB_IDX_BITS-1:0] widx;
  logic [TAG_W-1:0]        wtag;
  logic                    pht_we;
  logic [1:0]              pcur;
  logic [1:0]              pnxt;
  logic                    recover;

  assign btb_we  = upd_valid && upd_taken;
  assign widx    = upd_pc[BTB_IDX_BITS+1:2];
  assign wtag    = upd_pc[31:BTB_IDX_BITS+2];
  assign pht_we  = upd_valid && upd_is_cond;
  assign pcur    = pht_q[upd_pht_idx];
  assign recover = upd_valid && upd_mispredict;

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Saturating 2-bit counter step for the resolved branch.
  always_comb begin
    pnxt = pcur;
    if (upd_taken) begin
      if (pcur != 2'b11) pnxt = pcur + 2'd1;
    end else begin
      if (pcur != 2'b00) pnxt = pcur - 2'd1;
    end
  end

  // History: repair on mispredict wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (recover) begin
      ghr_d = upd_is_cond ? shl(upd_ghr, upd_taken) : upd_ghr;
    end else if (!stall && hit_cond) begin
      ghr_d = shl(ghr_q, pred_taken);
    end
  end

  // Saturating statistics counters.
  always_comb begin
    lk_d = lk_q;
    mp_d = mp_q;
    if (!stall && lk_q != 32'hFFFF_FFFF) lk_d = lk_q + 32'd1;
    if (recover && mp_q != 32'hFFFF_FFFF) mp_d = mp_q + 32'd1;
  end

  // GHR and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
      lk_q  <= '0;
      mp_q  <= '0;
    end else begin
      ghr_q <= ghr_d;
      lk_q  <= lk_d;
      mp_q  <= mp_d;
    end
  end

  // BTB valid/type bits; taken resolutions install or replace the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cond_q  <= '0;
    end else if (btb_we) begin
      valid_q[widx] <= 1'b1;
      cond_q[widx]  <= upd_is_cond;
    end
  end

  // BTB tag and target payload; meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (!reset && btb_we) begin
      tag_q[widx] <= wtag;
      tgt_q[widx] <= upd_target;
    end
  end

  // Pattern history table, trained only by conditional branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_INIT;
    end else if (pht_we) begin
      pht_q[upd_pht_idx] <= pnxt;
    end
  end

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Bench for gshare_predictor_param: MODE 0/1/2 instances on shared stimulus,
// checked against a table-level model plus hand-computed expectations.
module tb_gshare_predictor_param;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [5:0]  upd_pht_idx;
  logic [5:0]  upd_ghr;
  logic        upd_mispredict;

  logic [31:0] o_pc  [3];
  logic        o_tk  [3];
  logic [5:0]  o_idx [3];
  logic [5:0]  o_ghr [3];
  logic [31:0] o_lk  [3];
  logic [31:0] o_mp  [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : gd
    gshare_predictor_param #(
      .BTB_IDX_BITS(5),
      .PHT_BITS(6),
      .GHR_BITS(6),
      .MODE(g),
      .PHT_INIT(2'b01)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .if_pc(if_pc),
      .pred_pc(o_pc[g]),
      .pred_taken(o_tk[g]),
      .pred_pht_idx(o_idx[g]),
      .pred_ghr(o_ghr[g]),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_is_cond(upd_is_cond),
      .upd_taken(upd_taken),
      .upd_target(upd_target),
      .upd_pht_idx(upd_pht_idx),
      .upd_ghr(upd_ghr),
      .upd_mispredict(upd_mispredict),
      .stat_lookups(o_lk[g]),
      .stat_mispredicts(o_mp[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: BTB as plain arrays, PHT as ints, one history per mode.
  bit          mv  [32];
  logic [31:0] mt  [32];
  logic [31:0] mtg [32];
  bit          mc  [32];
  int          mph [64];
  int          mg  [3];
  logic [31:0] ml;
  logic [31:0] mm;
  bit          mok = 0;

  function automatic void mpred(input int m, input logic [31:0] pc,
                                output bit tk, output logic [31:0] npc,
                                output int pi, output bit hc);
    int b;
    bit hit;
    b   = int'((pc >> 2) % 32);
    hit = mv[b] && (mt[b] == (pc >> 7));
    if (m == 2) pi = int'((pc >> 2) % 64) ^ mg[m];
    else if (m == 1) pi = int'((pc >> 2) % 64);
    else pi = 0;
    tk  = hit && (!mc[b] || (m != 0 && mph[pi] >= 2));
    npc = tk ? mtg[b] : pc + 32'd4;
    hc  = hit && mc[b];
  endfunction

  always @(posedge clk) begin
    bit tk;
    bit hc;
    logic [31:0] npc;
    int pi;
    int b;
    if (reset) begin
      for (int i = 0; i < 32; i++) mv[i] = 0;
      for (int i = 0; i < 64; i++) mph[i] = 1;
      for (int i = 0; i < 3; i++) mg[i] = 0;
      ml  = 0;
      mm  = 0;
      mok = 1;
    end else if (mok) begin
      for (int m = 0; m < 3; m++) begin
        mpred(m, if_pc, tk, npc, pi, hc);
        if (upd_valid && upd_mispredict)
          mg[m] = upd_is_cond ?
                  (int'(upd_ghr) * 2 + int'(upd_taken)) % 64 :
                  int'(upd_ghr);
        else if (!stall && hc)
          mg[m] = (mg[m] * 2 + int'(tk)) % 64;
      end
      if (upd_valid && upd_is_cond) begin
        if (upd_taken) mph[upd_pht_idx] = (mph[upd_pht_idx] < 3) ?
                                          mph[upd_pht_idx] + 1 : 3;
        else mph[upd_pht_idx] = (mph[upd_pht_idx] > 0) ?
                                mph[upd_pht_idx] - 1 : 0;
      end
      if (upd_valid && upd_taken) begin
        b      = int'((upd_pc >> 2) % 32);
        mv[b]  = 1;
        mt[b]  = upd_pc >> 7;
        mtg[b] = upd_target;
        mc[b]  = upd_is_cond;
      end
      if (!stall && ml != 32'hFFFF_FFFF) ml = ml + 1;
      if (upd_valid && upd_mispredict && mm != 32'hFFFF_FFFF) mm = mm + 1;
    end
  end

  // Every cycle once the model is known, all three instances vs the model.
  always @(negedge clk) begin
    bit tk;
    bit hc;
    logic [31:0] npc;
    int pi;
    if (mok) begin
      for (int m = 0; m < 3; m++) begin
        mpred(m, if_pc, tk, npc, pi, hc);
        chk($sformatf("m%0d pred_taken", m), 32'(o_tk[m]), 32'(tk));
        chk($sformatf("m%0d pred_pc", m), o_pc[m], npc);
        chk($sformatf("m%0d pred_pht_idx", m), 32'(o_idx[m]), 32'(pi));
        chk($sformatf("m%0d pred_ghr", m), 32'(o_ghr[m]), 32'(mg[m]));
        chk($sformatf("m%0d stat_lookups", m), o_lk[m], ml);
        chk($sformatf("m%0d stat_mispredicts", m), o_mp[m], mm);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic c, input logic t,
                     input logic [31:0] tg, input logic [5:0] ix,
                     input logic [5:0] gh, input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_cond    = c;
    upd_taken      = t;
    upd_target     = tg;
    upd_pht_idx    = ix;
    upd_ghr        = gh;
    upd_mispredict = mp;
  endtask

  task automatic noupd();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    if_pc = 32'h100;
    upd(32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 6'd0, 1'b0);
    noupd();
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst pred_taken", 32'(o_tk[2]), 32'd0);
    chk("rst pred_pc", o_pc[2], 32'h104);
    chk("rst pred_ghr", 32'(o_ghr[2]), 32'd0);
    chk("rst stat_lookups", o_lk[2], 32'd0);
    chk("rst stat_mispredicts", o_mp[2], 32'd0);

    cyc();
    upd(32'h100, 1'b0, 1'b1, 32'h200, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("same-cycle old entry", o_pc[2], 32'h104);
    chk("lookups after one fetch", o_lk[2], 32'd1);

    cyc();
    noupd();
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("jump hit m%0d", g), o_pc[g], 32'h200);

    cyc();
    if_pc = 32'h1100;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("tag miss m%0d", g), o_pc[g], 32'h1104);

    cyc();
    upd(32'h40, 1'b1, 1'b1, 32'h80, 6'd16, 6'd0, 1'b0);
    cyc();
    cyc();
    upd(32'h304, 1'b0, 1'b1, 32'h400, 6'd0, 6'd0, 1'b1);
    cyc();
    noupd();
    stall = 1'b1;
    if_pc = 32'h40;
    @(negedge clk);
    chk("gshare taken pc", o_pc[2], 32'h80);
    chk("gshare pht idx", 32'(o_idx[2]), 32'd16);
    chk("bimodal taken pc", o_pc[1], 32'h80);
    chk("static cond pc", o_pc[0], 32'h44);
    chk("ghr after repair", 32'(o_ghr[2]), 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc();
      upd(32'h40, 1'b1, 1'b0, 32'h80, 6'd16, 6'd0, 1'b0);
    end
    cyc();
    noupd();
    @(negedge clk);
    chk("ctr 0 pred_pc", o_pc[2], 32'h44);
    chk("ctr 0 pred_taken", 32'(o_tk[2]), 32'd0);

    cyc();
    upd(32'h40, 1'b1, 1'b0, 32'h80, 6'd16, 6'd0, 1'b0);
    cyc();
    upd(32'h40, 1'b1, 1'b1, 32'h80, 6'd16, 6'd0, 1'b0);
    cyc();
    noupd();
    @(negedge clk);
    chk("low sat then taken", o_pc[2], 32'h44);

    for (int i = 0; i < 4; i++) begin
      cyc();
      upd(32'h40, 1'b1, 1'b1, 32'h80, 6'd16, 6'd0, 1'b0);
    end
    cyc();
    upd(32'h40, 1'b1, 1'b0, 32'h80, 6'd16, 6'd0, 1'b0);
    cyc();
    noupd();
    @(negedge clk);
    chk("high sat then nt", o_pc[2], 32'h80);

    cyc();
    stall = 1'b0;
    cyc();
    cyc();
    cyc();
    stall = 1'b1;
    @(negedge clk);
    chk("spec ghr bimodal", 32'(o_ghr[1]), 32'h07);
    chk("spec ghr gshare", 32'(o_ghr[2]), 32'h04);
    chk("spec ghr static", 32'(o_ghr[0]), 32'h00);

    repeat (3) cyc();
    @(negedge clk);
    chk("stall ghr bimodal", 32'(o_ghr[1]), 32'h07);
    chk("stall ghr gshare", 32'(o_ghr[2]), 32'h04);

    cyc();
    stall = 1'b0;
    upd(32'h40, 1'b1, 1'b0, 32'h0, 6'd40, 6'b000101, 1'b1);
    cyc();
    noupd();
    stall = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("repair ghr m%0d", g), 32'(o_ghr[g]), 32'h0A);
    chk("mispredict count", o_mp[2], 32'd2);

    cyc();
    reset = 1'b1;
    upd(32'h500, 1'b0, 1'b1, 32'h600, 6'd0, 6'd0, 1'b0);
    cyc();
    reset = 1'b0;
    noupd();
    stall = 1'b0;
    if_pc = 32'h500;
    @(negedge clk);
    chk("write under reset", o_pc[2], 32'h504);
    chk("stats cleared lk", o_lk[2], 32'd0);
    chk("stats cleared mp", o_mp[2], 32'd0);

    cyc();
    if_pc = 32'h100;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("btb cleared m%0d", g), o_pc[g], 32'h104);

    for (int i = 0; i < 16; i++) begin
      cyc();
      upd(32'h2000 + 32'(8 * i), 1'(i % 2), 1'(i % 3 != 0),
          32'h3000 + 32'(16 * i), 6'((i * 5) % 64), 6'(i), 1'(i % 4 == 0));
      if_pc = 32'h2000 + 32'(8 * ((i + 13) % 16));
      stall = 1'(i % 5 == 0);
    end
    cyc();
    noupd();
    stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if_pc = 32'h2000 + 32'(8 * i);
    end
    cyc();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
